// File: rtl/char_buffer_arbiter_pkg.sv
// Shared constants, FSM state encoding and helpers for the character buffer arbiter.
// Optional RAM clear after reset is built in when CHARBUF_CLEAR_EN is defined.
package char_buffer_arbiter_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int CHAR_W = 16;
  localparam int CHAR_H = 32;
  localparam int HBP    = 248;
  localparam int VBP    = 150;
  localparam int ADDR_W = 11;
  localparam int HV_W   = 11;

  localparam int CELLS   = COLS * ROWS;
  localparam int H_START = HBP - CHAR_W;
  localparam int H_END   = HBP + COLS * CHAR_W;
  localparam int V_END   = VBP + ROWS * CHAR_H;
  localparam int PH_W    = $clog2(CHAR_W);
  localparam int COL_W   = $clog2(COLS + 2);
  localparam int LINE_W  = $clog2(CHAR_H);

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ACK   = 3'd3,
    ST_CLEAR = 3'd4
  } cpu_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(CELLS);
  endfunction

endpackage

// File: rtl/char_buffer_arbiter_if.sv
// CPU request port and single-port character RAM bus of the character buffer arbiter.
interface char_buffer_arbiter_if;
  import char_buffer_arbiter_pkg::*;

  // CPU handshake: cpu_req and its qualifiers are held stable until the
  // one-cycle cpu_ack pulse; cpu_rdata is valid only while cpu_ack is high,
  // and the requester drops cpu_req in the cycle after cpu_ack.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/char_buffer_arbiter_cell_fetch_timer.sv
// Decodes the character fetch window from hc/vc and produces the video slot,
// the linear fetch address and the last-pixel-of-cell strobe.
module cell_fetch_timer
  import char_buffer_arbiter_pkg::*;
(
  input  logic              px_clk,
  input  logic              clr,
  input  logic [HV_W-1:0]   hc,
  input  logic [HV_W-1:0]   vc,
  output logic              slot,
  output logic              cell_end,
  output logic [ADDR_W-1:0] fetch_addr
);

  logic              in_h, in_v, h_start, h_last, v_first;
  logic [PH_W-1:0]   phase_q, phase_cur;
  logic [COL_W-1:0]  col_q, col_cur;
  logic [LINE_W-1:0] line_q, line_cur;
  logic [ADDR_W-1:0] row_base_q, row_base_cur;

  assign in_h    = (hc >= HV_W'(H_START)) && (hc < HV_W'(H_END));
  assign in_v    = (vc >= HV_W'(VBP)) && (vc < HV_W'(V_END));
  assign h_start = (hc == HV_W'(H_START));
  assign h_last  = (hc == HV_W'(H_END - 1));
  assign v_first = (vc == HV_W'(VBP));

  // Registers hold the value for the next cycle; the window start and the
  // first visible line override them so counting begins on the exact cycle.
  assign phase_cur    = h_start ? '0 : phase_q;
  assign col_cur      = h_start ? '0 : col_q;
  assign line_cur     = v_first ? '0 : line_q;
  assign row_base_cur = v_first ? '0 : row_base_q;

  assign slot       = in_h && in_v && (phase_cur == '0) && (col_cur < COL_W'(COLS));
  assign cell_end   = in_h && in_v && (phase_cur == PH_W'(CHAR_W - 1));
  assign fetch_addr = row_base_cur + ADDR_W'(col_cur);

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      phase_q    <= '0;
      col_q      <= '0;
      line_q     <= '0;
      row_base_q <= '0;
    end else begin
      if (in_h) begin
        // CHAR_W is a power of two, so the phase wraps on its own.
        phase_q <= phase_cur + 1'b1;
        col_q   <= (phase_cur == PH_W'(CHAR_W - 1)) ? col_cur + 1'b1 : col_cur;
      end
      if (in_v && h_last) begin
        if (line_cur == LINE_W'(CHAR_H - 1)) begin
          line_q     <= '0;
          row_base_q <= row_base_cur + ADDR_W'(COLS);
        end else begin
          line_q     <= line_cur + 1'b1;
          row_base_q <= row_base_cur;
        end
      end
    end
  end

endmodule

// File: rtl/char_buffer_arbiter.sv
// Arbitrates the character RAM between fixed video fetch slots and the CPU port.
// Define CHARBUF_CLEAR_EN to fill the RAM with spaces after every reset.
module char_buffer_arbiter
  import char_buffer_arbiter_pkg::*;
(
  input  logic                 px_clk,
  input  logic                 clr,
  input  logic [HV_W-1:0]      hc,
  input  logic [HV_W-1:0]      vc,
  char_buffer_arbiter_if.slave bus,
  output logic [7:0]           char_code,
  output logic                 char_valid,
  output logic                 clearing,
  output cpu_state_e           state_dbg
);

  logic              slot, cell_end;
  logic [ADDR_W-1:0] fetch_addr;
  cpu_state_e        state_q;
  logic              vid_bus_q, vid_data_q, hold_valid_q;
  logic [7:0]        hold_q;
  logic              cpu_oob_q;
  logic              accept;

  cell_fetch_timer u_timer (
    .px_clk     (px_clk),
    .clr        (clr),
    .hc         (hc),
    .vc         (vc),
    .slot       (slot),
    .cell_end   (cell_end),
    .fetch_addr (fetch_addr)
  );

  assign state_dbg = state_q;
  assign accept    = (state_q == ST_IDLE) && !clearing && bus.cpu_req && !slot;

  // Video pipeline: address on bus one cycle after the slot, data the cycle after.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      vid_bus_q    <= 1'b0;
      vid_data_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      char_code    <= '0;
      char_valid   <= 1'b0;
    end else begin
      vid_bus_q  <= slot;
      vid_data_q <= vid_bus_q;
      if (vid_data_q) begin
        hold_q       <= bus.mem_rdata;
        hold_valid_q <= 1'b1;
      end
      char_valid <= 1'b0;
      if (cell_end) begin
        char_valid   <= hold_valid_q;
        hold_valid_q <= 1'b0;
        if (hold_valid_q) char_code <= hold_q;
      end
    end
  end

`ifdef CHARBUF_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q;
`endif

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
`ifdef CHARBUF_CLEAR_EN
      state_q    <= ST_CLEAR;
      clearing   <= 1'b1;
      clr_addr_q <= '0;
`else
      state_q    <= ST_IDLE;
`endif
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      cpu_oob_q     <= 1'b0;
    end else begin
      bus.mem_we  <= 1'b0;
      bus.cpu_ack <= 1'b0;
      if (slot) bus.mem_addr <= fetch_addr;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_we    <= bus.cpu_we && addr_in_range(bus.cpu_addr);
            bus.mem_wdata <= bus.cpu_wdata;
            cpu_oob_q     <= !addr_in_range(bus.cpu_addr);
            state_q       <= ST_ADDR;
          end
        end
        ST_ADDR: state_q <= ST_DATA;
        ST_DATA: begin
          bus.cpu_rdata <= cpu_oob_q ? 8'h00 : bus.mem_rdata;
          bus.cpu_ack   <= 1'b1;
          state_q       <= ST_ACK;
        end
        ST_ACK: state_q <= ST_IDLE;
`ifdef CHARBUF_CLEAR_EN
        ST_CLEAR: begin
          if (!slot) begin
            bus.mem_addr  <= clr_addr_q;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= SPACE_CHAR;
            clr_addr_q    <= clr_addr_q + 1'b1;
            if (clr_addr_q == ADDR_W'(CELLS - 1)) state_q <= ST_IDLE;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
`ifdef CHARBUF_CLEAR_EN
      // Lags the state by one cycle so it falls after the last write lands.
      clearing <= (state_q == ST_CLEAR);
`endif
    end
  end

`ifndef CHARBUF_CLEAR_EN
  assign clearing = 1'b0;
`endif

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Directed bench for char_buffer_arbiter: video fetch timing, CPU handshake, abort on reset.
module tb_char_buffer_arbiter;
  import char_buffer_arbiter_pkg::*;

  logic       px_clk = 1'b0;
  logic       clr;
  logic [10:0] hc, vc;
  logic [7:0] char_code;
  logic       char_valid, clearing;
  cpu_state_e state_dbg;

  char_buffer_arbiter_if bus ();

  char_buffer_arbiter dut (
    .px_clk     (px_clk),
    .clr        (clr),
    .hc         (hc),
    .vc         (vc),
    .bus        (bus),
    .char_code  (char_code),
    .char_valid (char_valid),
    .clearing   (clearing),
    .state_dbg  (state_dbg)
  );

`ifdef CHARBUF_CLEAR_EN
  localparam logic [31:0] RST_STATE = 32'(ST_CLEAR);
  localparam logic [31:0] RST_CLEARING = 32'd1;
`else
  localparam logic [31:0] RST_STATE = 32'(ST_IDLE);
  localparam logic [31:0] RST_CLEARING = 32'd0;
`endif

  // clock / reset
  always #5 px_clk = ~px_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // RAM model: single port, one-clock read latency
  logic [7:0] ram [0:2047];
  always @(posedge px_clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_checks, n_errors, cv_count, lat, wait_n, bad;
  logic [7:0] rd;
  logic mon_en, ack_seen, early_ack, got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard for presented characters
  logic [7:0]  exp_q[$];
  logic [10:0] exp_hc_q[$];

  always @(negedge px_clk) begin
    if (!clr && char_valid) begin
      cv_count++;
      if (mon_en) begin
        if (exp_q.size() == 0) check("char_valid_extra", 32'd1, 32'd0);
        else begin
          check("char_code", 32'(char_code), 32'(exp_q.pop_front()));
          check("char_hc", 32'(hc), 32'(exp_hc_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic drive_cycle(input int h, input int v);
    @(posedge px_clk); #1;
    hc = 11'(h);
    vc = 11'(v);
    @(negedge px_clk);
  endtask

  // lat = cycles from request cycle to ack cycle, -1 on timeout
  task automatic cpu_xfer(input logic we, input int addr, input logic [7:0] wd,
                          output logic [7:0] rdata, output int latency);
    logic done;
    @(posedge px_clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = 11'(addr); bus.cpu_wdata = wd;
    latency = -1; rdata = 8'h00; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge px_clk);
      if (bus.cpu_ack) begin
        done = 1'b1; latency = i; rdata = bus.cpu_rdata;
      end
    end
    @(posedge px_clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cv_count = 0; mon_en = 1'b0;
    clr = 1'b1; hc = '0; vc = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_char_code", 32'(char_code), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_clearing", 32'(clearing), RST_CLEARING);
    check("rst_state", 32'(state_dbg), RST_STATE);
    @(posedge px_clk); #1;
    clr = 1'b0;

`ifdef CHARBUF_CLEAR_EN
    // CPU write queued during clear must wait for clearing to fall
    @(posedge px_clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'd3; bus.cpu_wdata = 8'h66;
    early_ack = 1'b0; wait_n = 0;
    while (clearing && wait_n < 5000) begin
      @(negedge px_clk);
      if (bus.cpu_ack) early_ack = 1'b1;
      wait_n++;
    end
    check("clear_done", 32'(clearing), 32'd0);
    check("clear_no_early_ack", 32'(early_ack), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge px_clk);
      if (bus.cpu_ack) got = 1'b1;
    end
    check("clear_then_ack", 32'(got), 32'd1);
    @(posedge px_clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge px_clk);
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (i != 3 && ram[i] != 8'h20) bad++;
    check("clear_fill", 32'(bad), 32'd0);
    check("clear_cpu_write", 32'(ram[3]), 32'h66);
`endif

    // first visible text row, full line
    for (int i = 1; i < COLS - 1; i++) ram[i] = 8'h30 + 8'(i % 40);
    ram[0] = 8'h41;
    ram[COLS-1] = 8'h5A;
    for (int i = 0; i < COLS; i++) begin
      exp_q.push_back(ram[i]);
      exp_hc_q.push_back(11'(HBP + i * CHAR_W));
    end
    cv_count = 0; mon_en = 1'b1;
    for (int h = 200; h <= 1540; h++) drive_cycle(h, VBP);
    check("line0_pulses", 32'(cv_count), 32'd80);
    check("line0_queue_empty", 32'(exp_q.size()), 32'd0);

    // step through the remaining lines of row 0
    for (int v = VBP + 1; v < VBP + CHAR_H; v++) drive_cycle(H_END - 1, v);

    // row 1, first cell
    ram[80] = 8'h42;
    exp_q.push_back(8'h42);
    exp_hc_q.push_back(11'(HBP));
    for (int h = 200; h <= 260; h++) begin
      drive_cycle(h, VBP + CHAR_H);
      if (h == 233) begin
        check("row1_fetch_addr", 32'(bus.mem_addr), 32'd80);
        check("row1_fetch_no_we", 32'(bus.mem_we), 32'd0);
      end
    end
    check("row1_queue_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // CPU write raised on a video slot cycle
    for (int h = 228; h <= 240; h++) begin
      @(posedge px_clk); #1;
      hc = 11'(h); vc = 11'(VBP + CHAR_H + 1);
      if (h == 232) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'd5; bus.cpu_wdata = 8'h33;
      end
      if (h == 237) bus.cpu_req = 1'b0;
      @(negedge px_clk);
      case (h)
        233: begin
          check("slot_video_addr", 32'(bus.mem_addr), 32'd80);
          check("slot_video_we", 32'(bus.mem_we), 32'd0);
        end
        234: begin
          check("slot_cpu_addr", 32'(bus.mem_addr), 32'd5);
          check("slot_cpu_we", 32'(bus.mem_we), 32'd1);
          check("slot_cpu_wdata", 32'(bus.mem_wdata), 32'h33);
        end
        235: check("slot_ack_early", 32'(bus.cpu_ack), 32'd0);
        236: check("slot_ack", 32'(bus.cpu_ack), 32'd1);
        237: check("slot_ack_pulse", 32'(bus.cpu_ack), 32'd0);
        default: ;
      endcase
    end
    check("slot_ram_written", 32'(ram[5]), 32'h33);

    // CPU transfers outside the window
    drive_cycle(0, 0);
    cpu_xfer(1'b0, 5, 8'h00, rd, lat);
    check("rd5_latency", 32'(lat), 32'd3);
    check("rd5_data", 32'(rd), 32'h33);

    ram[2000] = 8'h99;
    cpu_xfer(1'b1, 2000, 8'h77, rd, lat);
    check("oob_wr_latency", 32'(lat), 32'd3);
    check("oob_wr_rdata", 32'(rd), 32'h00);
    check("oob_wr_ram", 32'(ram[2000]), 32'h99);
    cpu_xfer(1'b0, 2000, 8'h00, rd, lat);
    check("oob_rd_latency", 32'(lat), 32'd3);
    check("oob_rd_data", 32'(rd), 32'h00);

    cpu_xfer(1'b1, CELLS - 1, 8'hAB, rd, lat);
    check("last_wr_ram", 32'(ram[CELLS-1]), 32'hAB);
    cpu_xfer(1'b0, CELLS - 1, 8'h00, rd, lat);
    check("last_rd_latency", 32'(lat), 32'd3);
    check("last_rd_data", 32'(rd), 32'hAB);

    // reset while the write address is on the bus
    ram[7] = 8'h11;
    @(posedge px_clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'd7; bus.cpu_wdata = 8'h55;
    @(posedge px_clk); #1;
    check("abort_in_addr", 32'(state_dbg), 32'(ST_ADDR));
    clr = 1'b1;
    #1;
    check("abort_mem_we", 32'(bus.mem_we), 32'd0);
    check("abort_state", 32'(state_dbg), RST_STATE);
    bus.cpu_req = 1'b0;
    @(posedge px_clk); #1;
    clr = 1'b0;
    check("abort_ram_kept", 32'(ram[7]), 32'h11);
    ack_seen = 1'b0;
    repeat (6) begin
      @(negedge px_clk);
      if (bus.cpu_ack) ack_seen = 1'b1;
    end
    check("abort_no_ack", 32'(ack_seen), 32'd0);

`ifdef CHARBUF_CLEAR_EN
    wait_n = 0;
    while (clearing && wait_n < 5000) begin
      @(negedge px_clk);
      wait_n++;
    end
    check("reclear_done", 32'(clearing), 32'd0);
    check("reclear_ram7", 32'(ram[7]), 32'h20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
